// File: rtl/data_stack.sv
// Register-based operand stack for the stack16 datapath: Tos/Nos feed the ALU directly,
// deeper entries spill into an array, and depth plus sticky overflow/underflow error are tracked.
module data_stack #(
   parameter int DEPTH = 16,
   parameter int DW    = 16
) (
   input  logic                       Clock,
   input  logic                       Reset_n,
   input  logic [2:0]                 Cmd,
   input  logic [DW-1:0]              Din,
   input  logic [DW-1:0]              Result,
   input  logic [2:0]                 AluFlags,
   output logic [DW-1:0]              Tos,
   output logic [DW-1:0]              Nos,
   output logic [$clog2(DEPTH+1)-1:0] Depth,
   output logic                       Empty,
   output logic                       Full,
   output logic [2:0]                 Flags,
   output logic                       Error
);

   localparam int DPW = $clog2(DEPTH+1);
   localparam int AW  = (DEPTH > 3) ? $clog2(DEPTH-2) : 1;
   localparam logic [DPW-1:0] DEPTH_D = DPW'(DEPTH);
   localparam logic [DPW-1:0] ONE     = DPW'(1);
   localparam logic [DPW-1:0] TWO     = DPW'(2);
   localparam logic [DPW-1:0] THREE   = DPW'(3);

   typedef enum logic [2:0] {
      CMD_NOP   = 3'b000,
      CMD_PUSH  = 3'b001,
      CMD_DROP  = 3'b010,
      CMD_BINOP = 3'b011,
      CMD_UNOP  = 3'b100,
      CMD_DUP   = 3'b101,
      CMD_SWAP  = 3'b110,
      CMD_OVER  = 3'b111
   } cmd_e;

   cmd_e           cmd;
   logic [DW-1:0]  spill [DEPTH-2];
   logic [AW-1:0]  wr_idx;
   logic [AW-1:0]  rd_idx;
   logic [DW-1:0]  arr_top;

   logic [DW-1:0]  next_tos;
   logic [DW-1:0]  next_nos;
   logic [DPW-1:0] next_depth;
   logic [2:0]     next_flags;
   logic           next_error;
   logic           spill_we;
   logic           do_push;
   logic [DW-1:0]  push_data;

   assign cmd    = cmd_e'(Cmd);
   assign wr_idx = AW'(Depth - TWO);
   assign rd_idx = AW'(Depth - THREE);
   // The array only holds live data once more than Tos and Nos are occupied.
   assign arr_top = (Depth > TWO) ? spill[rd_idx] : '0;

   always_comb begin
      next_tos   = Tos;
      next_nos   = Nos;
      next_depth = Depth;
      next_flags = Flags;
      next_error = Error;
      spill_we   = 1'b0;
      do_push    = 1'b0;
      push_data  = Din;
      unique case (cmd)
         CMD_NOP: ;
         CMD_PUSH: begin
            if (Depth < DEPTH_D) do_push = 1'b1;
            else                 next_error = 1'b1;
         end
         CMD_DUP: begin
            push_data = Tos;
            if (Depth >= ONE && Depth < DEPTH_D) do_push = 1'b1;
            else                                 next_error = 1'b1;
         end
         CMD_OVER: begin
            push_data = Nos;
            if (Depth >= TWO && Depth < DEPTH_D) do_push = 1'b1;
            else                                 next_error = 1'b1;
         end
         CMD_DROP: begin
            if (Depth >= ONE) begin
               next_tos   = Nos;
               next_nos   = arr_top;
               next_depth = Depth - ONE;
            end else begin
               next_error = 1'b1;
            end
         end
         CMD_BINOP: begin
            if (Depth >= TWO) begin
               next_tos   = Result;
               next_nos   = arr_top;
               next_depth = Depth - ONE;
               next_flags = AluFlags;
            end else begin
               next_error = 1'b1;
            end
         end
         CMD_UNOP: begin
            if (Depth >= ONE) begin
               next_tos   = Result;
               next_flags = AluFlags;
            end else begin
               next_error = 1'b1;
            end
         end
         CMD_SWAP: begin
            if (Depth >= TWO) begin
               next_tos = Nos;
               next_nos = Tos;
            end else begin
               next_error = 1'b1;
            end
         end
         default: ;
      endcase
      if (do_push) begin
         spill_we   = (Depth >= TWO);
         next_nos   = Tos;
         next_tos   = push_data;
         next_depth = Depth + ONE;
      end
      // Vacated registers read back as zero so Tos/Nos never expose stale data.
      if (next_depth < TWO)  next_nos = '0;
      if (next_depth == '0)  next_tos = '0;
   end

   always_ff @(posedge Clock or negedge Reset_n) begin
      if (!Reset_n) begin
         Tos   <= '0;
         Nos   <= '0;
         Depth <= '0;
         Flags <= '0;
         Error <= 1'b0;
      end else begin
         Tos   <= next_tos;
         Nos   <= next_nos;
         Depth <= next_depth;
         Flags <= next_flags;
         Error <= next_error;
      end
   end

   always_ff @(posedge Clock) begin
      if (spill_we) spill[wr_idx] <= Nos;
   end

   assign Empty = (Depth == '0);
   assign Full  = (Depth == DEPTH_D);

endmodule

// File: tb/tb_data_stack.sv
// Self-checking bench for data_stack: table-driven vectors through a scoreboard queue,
// plus hand-written fill/overflow, underflow and asynchronous-reset sequences.
module tb_data_stack;

   localparam logic [2:0] NOP = 3'b000, PUSH = 3'b001, DROP = 3'b010, BINOP = 3'b011;
   localparam logic [2:0] UNOP = 3'b100, DUP = 3'b101, SWAP = 3'b110, OVER = 3'b111;

   typedef struct {
      logic [2:0]  cmd;
      logic [15:0] din;
      logic [15:0] result;
      logic [2:0]  af;
      logic [15:0] tos;
      logic [15:0] nos;
      logic [4:0]  depth;
      logic [2:0]  flags;
      logic        error;
   } vec_t;

   logic        Clock = 1'b0;
   logic        Reset_n = 1'b0;
   logic [2:0]  Cmd = NOP;
   logic [15:0] Din = '0;
   logic [15:0] Result = '0;
   logic [2:0]  AluFlags = '0;
   logic [15:0] Tos;
   logic [15:0] Nos;
   logic [4:0]  Depth;
   logic        Empty;
   logic        Full;
   logic [2:0]  Flags;
   logic        Error;

   int   checks = 0;
   int   errors = 0;
   vec_t sb[$];
   vec_t table_vecs[$];

   data_stack #(.DEPTH(16), .DW(16)) dut (
      .Clock(Clock), .Reset_n(Reset_n), .Cmd(Cmd), .Din(Din), .Result(Result),
      .AluFlags(AluFlags), .Tos(Tos), .Nos(Nos), .Depth(Depth), .Empty(Empty),
      .Full(Full), .Flags(Flags), .Error(Error)
   );

   always #5 Clock = ~Clock;

   function automatic vec_t mk(input logic [2:0] cmd, input logic [15:0] din,
                               input logic [15:0] result, input logic [2:0] af,
                               input logic [15:0] tos, input logic [15:0] nos,
                               input logic [4:0] depth, input logic [2:0] flags,
                               input logic error);
      vec_t v;
      v.cmd = cmd; v.din = din; v.result = result; v.af = af;
      v.tos = tos; v.nos = nos; v.depth = depth; v.flags = flags; v.error = error;
      return v;
   endfunction

   task automatic cmp(input string name, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
      end
   endtask

   task automatic checkOutput(input string tag, input vec_t e);
      cmp({tag, ".tos"},   Tos, e.tos);
      cmp({tag, ".nos"},   Nos, e.nos);
      cmp({tag, ".depth"}, 16'(Depth), 16'(e.depth));
      cmp({tag, ".flags"}, 16'(Flags), 16'(e.flags));
      cmp({tag, ".error"}, 16'(Error), 16'(e.error));
      cmp({tag, ".empty"}, 16'(Empty), 16'(e.depth == 5'd0));
      cmp({tag, ".full"},  16'(Full),  16'(e.depth == 5'd16));
   endtask

   // Drive one command at the falling edge, queue its expectation, compare after the rising edge.
   task automatic applyStimulus(input string tag, input vec_t v);
      vec_t e;
      @(negedge Clock);
      Cmd = v.cmd; Din = v.din; Result = v.result; AluFlags = v.af;
      sb.push_back(v);
      @(posedge Clock);
      #1;
      if (sb.size() == 0) begin
         checks++; errors++;
         $display("[TB] FAIL %s.scoreboard: got empty queue expected entry", tag);
      end else begin
         e = sb.pop_front();
         checkOutput(tag, e);
      end
      Cmd = NOP;
   endtask

   task automatic doReset();
      @(negedge Clock);
      Reset_n = 1'b0;
      @(negedge Clock);
      Reset_n = 1'b1;
   endtask

   initial begin
      vec_t rst_exp;
      rst_exp = mk(NOP, 0, 0, 0, 16'h0, 16'h0, 5'd0, 3'b000, 1'b0);

      #2;
      checkOutput("reset", rst_exp);
      @(negedge Clock);
      Reset_n = 1'b1;

      table_vecs.push_back(mk(PUSH,  16'h1111, 0, 0, 16'h1111, 16'h0000, 5'd1, 3'b000, 0));
      table_vecs.push_back(mk(PUSH,  16'h2222, 0, 0, 16'h2222, 16'h1111, 5'd2, 3'b000, 0));
      table_vecs.push_back(mk(PUSH,  16'h3333, 0, 0, 16'h3333, 16'h2222, 5'd3, 3'b000, 0));
      table_vecs.push_back(mk(DROP,  0, 0, 0, 16'h2222, 16'h1111, 5'd2, 3'b000, 0));
      table_vecs.push_back(mk(DROP,  0, 0, 0, 16'h1111, 16'h0000, 5'd1, 3'b000, 0));
      table_vecs.push_back(mk(DROP,  0, 0, 0, 16'h0000, 16'h0000, 5'd0, 3'b000, 0));
      table_vecs.push_back(mk(PUSH,  16'h0005, 0, 0, 16'h0005, 16'h0000, 5'd1, 3'b000, 0));
      table_vecs.push_back(mk(PUSH,  16'h0003, 0, 0, 16'h0003, 16'h0005, 5'd2, 3'b000, 0));
      table_vecs.push_back(mk(BINOP, 0, 16'h0008, 3'b000, 16'h0008, 16'h0000, 5'd1, 3'b000, 0));
      table_vecs.push_back(mk(UNOP,  0, 16'hFFF7, 3'b010, 16'hFFF7, 16'h0000, 5'd1, 3'b010, 0));
      table_vecs.push_back(mk(DROP,  0, 0, 0, 16'h0000, 16'h0000, 5'd0, 3'b010, 0));
      table_vecs.push_back(mk(PUSH,  16'hAAAA, 0, 0, 16'hAAAA, 16'h0000, 5'd1, 3'b010, 0));
      table_vecs.push_back(mk(PUSH,  16'h5555, 0, 0, 16'h5555, 16'hAAAA, 5'd2, 3'b010, 0));
      table_vecs.push_back(mk(SWAP,  0, 0, 0, 16'hAAAA, 16'h5555, 5'd2, 3'b010, 0));
      table_vecs.push_back(mk(OVER,  0, 0, 0, 16'h5555, 16'hAAAA, 5'd3, 3'b010, 0));
      table_vecs.push_back(mk(DUP,   0, 0, 0, 16'h5555, 16'h5555, 5'd4, 3'b010, 0));
      table_vecs.push_back(mk(BINOP, 0, 16'h1234, 3'b101, 16'h1234, 16'hAAAA, 5'd3, 3'b101, 0));
      table_vecs.push_back(mk(BINOP, 0, 16'h4321, 3'b001, 16'h4321, 16'h5555, 5'd2, 3'b001, 0));
      table_vecs.push_back(mk(UNOP,  0, 16'h0000, 3'b001, 16'h0000, 16'h5555, 5'd2, 3'b001, 0));
      table_vecs.push_back(mk(SWAP,  0, 0, 0, 16'h5555, 16'h0000, 5'd2, 3'b001, 0));
      table_vecs.push_back(mk(NOP,   16'hDEAD, 16'hBEEF, 3'b111, 16'h5555, 16'h0000, 5'd2, 3'b001, 0));
      table_vecs.push_back(mk(DROP,  0, 0, 0, 16'h0000, 16'h0000, 5'd1, 3'b001, 0));
      table_vecs.push_back(mk(DROP,  0, 0, 0, 16'h0000, 16'h0000, 5'd0, 3'b001, 0));

      for (int i = 0; i < table_vecs.size(); i++)
         applyStimulus($sformatf("vec%0d", i), table_vecs[i]);

      // Underflow is gated and sticky, but later legal commands still work.
      doReset();
      applyStimulus("uf_binop", mk(BINOP, 0, 16'h9999, 3'b111, 16'h0000, 16'h0000, 5'd0, 3'b000, 1));
      applyStimulus("uf_push",  mk(PUSH, 16'h0001, 0, 0, 16'h0001, 16'h0000, 5'd1, 3'b000, 1));
      applyStimulus("uf_swap",  mk(SWAP, 0, 0, 0, 16'h0001, 16'h0000, 5'd1, 3'b000, 1));
      applyStimulus("uf_drop",  mk(DROP, 0, 0, 0, 16'h0000, 16'h0000, 5'd0, 3'b000, 1));

      doReset();
      for (int i = 0; i < 16; i++)
         applyStimulus($sformatf("fill%0d", i),
                       mk(PUSH, 16'(i), 0, 0, 16'(i), (i > 0) ? 16'(i - 1) : 16'h0, 5'(i + 1), 3'b000, 0));
      applyStimulus("of_push", mk(PUSH, 16'hBEEF, 0, 0, 16'd15, 16'd14, 5'd16, 3'b000, 1));
      applyStimulus("of_dup",  mk(DUP, 0, 0, 0, 16'd15, 16'd14, 5'd16, 3'b000, 1));
      for (int k = 1; k <= 16; k++) begin
         int d;
         d = 16 - k;
         applyStimulus($sformatf("pop%0d", k),
                       mk(DROP, 0, 0, 0, (d > 0) ? 16'(d - 1) : 16'h0,
                          (d > 1) ? 16'(d - 2) : 16'h0, 5'(d), 3'b000, 1));
      end
      applyStimulus("uf_drop17", mk(DROP, 0, 0, 0, 16'h0, 16'h0, 5'd0, 3'b000, 1));

      // Asynchronous reset between edges must clear everything without a clock.
      doReset();
      applyStimulus("mr_err", mk(DROP, 0, 0, 0, 16'h0, 16'h0, 5'd0, 3'b000, 1));
      for (int i = 0; i < 5; i++)
         applyStimulus($sformatf("mr_push%0d", i),
                       mk(PUSH, 16'h0100 + 16'(i), 0, 0, 16'h0100 + 16'(i),
                          (i > 0) ? 16'h0100 + 16'(i - 1) : 16'h0, 5'(i + 1), 3'b000, 1));
      applyStimulus("mr_unop", mk(UNOP, 0, 16'h7777, 3'b110, 16'h7777, 16'h0103, 5'd5, 3'b110, 1));
      @(posedge Clock);
      #3;
      Reset_n = 1'b0;
      #1;
      checkOutput("mid_reset", rst_exp);
      @(negedge Clock);
      Reset_n = 1'b1;
      applyStimulus("post_reset", mk(PUSH, 16'h0042, 0, 0, 16'h0042, 16'h0000, 5'd1, 3'b000, 0));

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
